// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sequencer sharing one add/sub unit
// between two requesters, with a tagged valid/ready response.
module addsub_arbiter #(
  parameter int WIDTH   = 4,
  parameter int CNT_W   = 8,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_m,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_m,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             alu_m,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_s,
  input  logic             alu_carry,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_s,
  output logic             resp_carry,
  output logic [CNT_W-1:0] op_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_ptr;
  logic   w_gnt;
  logic   w_idle;
  logic   w_hs;
  logic   w_done;

  // grant selection and combinational ready; ready is held low in reset
  always_comb begin
    w_gnt  = 1'b0;
    w_idle = (r_state == S_IDLE) && !rst;
    if (req0_valid && req1_valid) begin
      w_gnt = r_ptr;
    end else begin
      w_gnt = req1_valid;
    end
    req0_ready = w_idle && req0_valid && !w_gnt;
    req1_ready = w_idle && req1_valid && w_gnt;
    w_hs       = req0_ready || req1_ready;
    w_done     = (r_state == S_RESP) && resp_ready;
    busy       = (r_state != S_IDLE);
  end

  // next-state logic; the unused code falls back to IDLE
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_hs ? S_EXEC : S_IDLE;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  w_next = w_done ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // operand latch, result capture, pointer and counter updates
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_m      <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_s     <= '0;
      resp_carry <= 1'b0;
      op_count   <= '0;
      r_ptr      <= RR_INIT;
    end else begin
      if (w_hs) begin
        alu_m   <= w_gnt ? req1_m : req0_m;
        alu_a   <= w_gnt ? req1_a : req0_a;
        alu_b   <= w_gnt ? req1_b : req0_b;
        resp_id <= w_gnt;
      end
      if (r_state == S_EXEC) begin
        resp_s     <= alu_s;
        resp_carry <= alu_carry;
        resp_valid <= 1'b1;
      end
      if (w_done) begin
        resp_valid <= 1'b0;
        op_count   <= op_count + CNT_W'(1);
        r_ptr      <= ~resp_id;
      end
    end
  end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-bit add/sub datapath between two requesters.
- Accepts an operation (mode M, operands a and b) from one requester at a time and drives it onto the shared unit's ports.
- Captures the unit's sum/carry and returns it on a tagged response channel with valid/ready backpressure.
- Sits between the two client blocks and the single combinational add/sub instance in the ALU top.

Parameters:
- WIDTH, 4, operand/result width; must match the shared add/sub unit.
- CNT_W, 8, width of the completed-operation counter.
- RR_INIT, 0, requester holding priority after reset (0 or 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_m  input  1  requester 0 mode: 0 = add, 1 = subtract.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req1_valid, req1_ready, req1_m, req1_a, req1_b: same as requester 0, for requester 1.
- alu_m  output  1  mode driven to the shared unit.
- alu_a, alu_b  output  WIDTH  operands driven to the shared unit.
- alu_s  input  WIDTH  sum from the shared unit.
- alu_carry  input  1  carry-out from the shared unit.
- resp_valid  output  1  response holding.
- resp_ready  input  1  consumer accepts the response.
- resp_id  output  1  requester that issued the operation.
- resp_s  output  WIDTH  captured result.
- resp_carry  output  1  captured carry.
- op_count  output  CNT_W  completed responses, wraps modulo 2^CNT_W.
- busy  output  1  high in EXEC or RESP.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - alu_m, alu_a, alu_b, resp_valid, resp_id, resp_s, resp_carry, op_count and busy all go to 0.
  - Priority pointer goes to RR_INIT.
  - Any in-flight operation is discarded; no response is ever produced for it. This applies equally when reset arrives during EXEC or RESP.
- State IDLE:
  - Grant goes to the requester holding valid. If both are valid, grant goes to the pointer's requester.
  - reqN_ready is combinational: it is 1 only in IDLE and only for the granted requester. Both ready signals are 0 in every other state.
  - On a handshake (valid and ready both high) the edge latches m, a, b into alu_m/alu_a/alu_b and latches the grant into resp_id. State goes to EXEC.
  - With no valid requester, state stays IDLE and the alu_* registers hold their values.
- State EXEC (one cycle):
  - alu_* are stable from registers.
  - At the end of the cycle alu_s and alu_carry are captured into resp_s and resp_carry, resp_valid is set to 1, and state goes to RESP.
- State RESP:
  - resp_* are held stable while resp_valid=1 and resp_ready=0, for any number of cycles.
  - On the edge where resp_ready=1: resp_valid clears to 0, op_count increments, the pointer is set to the requester that was not resp_id, and state goes to IDLE.
- Latency: handshake edge T → alu_* valid during T+1 → resp_valid high from edge T+2.
- Throughput: at most one operation per 3 cycles (back-to-back handshakes are 3 cycles apart with resp_ready tied high).
- No arithmetic is done in this block. The result and carry pass through unmodified, so sign and borrow semantics belong to the add/sub unit.
- op_count wraps from 2^CNT_W−1 to 0 with no flag.
- busy = (state != IDLE).
- Requester inputs are ignored outside IDLE. A requester may drop valid before ready without side effects.
- State encoding is 2 bits; the unused code returns to IDLE on the next edge.

Test Plan:
The bench drives alu_s/alu_carry from a behavioural model: M=0 → a+b, M=1 → a+~b+1, with carry-out.
- Reset: hold rst for 2 cycles with both requests valid → all outputs 0, both ready signals 0 during reset, first grant after release goes to req0 (RR_INIT=0).
- Single op: req0 add, a=3, b=5, handshake at T → alu_a=3, alu_b=5, alu_m=0 at T+1; resp_valid at T+2 with resp_s=8, resp_carry=0, resp_id=0; op_count=1.
- Contention: both valid from reset; req0 add 3+5, req1 sub 5−3 → req0 served first (s=8), then req1 (resp_s=2, resp_carry=1, resp_id=1). A third contention grants req0 again.
- Backpressure: resp_ready=0 for 4 cycles in RESP → resp_* unchanged, req0_ready=req1_ready=0, op_count unchanged. resp_ready=1 → IDLE next cycle.
- Overflow/wrap: add 9+9 → resp_s=2, resp_carry=1. Run 256 ops → op_count returns to 0.
- Reset mid-op: assert rst during EXEC → no resp_valid afterwards, op_count=0, next grant is to RR_INIT.
